// File: rtl/pll_cfg_pkg.sv
// Shared configuration for the PLL reconfiguration sequencer: widths,
// default timing, state constants and the divider profile table.
package pll_cfg_pkg;

    localparam int unsigned CODE_W  = 7;
    localparam int unsigned PROF_W  = 2;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned LOSS_W  = 8;

    // Default timing at the 50 MHz board clock
    localparam int unsigned DEF_NPROF        = 4;
    localparam int unsigned DEF_RESET_CYCLES = 16;
    localparam int unsigned DEF_GATE_CYCLES  = 4;
    localparam int unsigned DEF_LOCK_STABLE  = 1024;
    localparam int unsigned DEF_LOCK_TIMEOUT = 500000;
    localparam int unsigned DEF_MAX_RETRY    = 3;

    // Sequencer states
    localparam logic [STATE_W-1:0] ST_GATE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_PRESET    = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 3'd2;
    localparam logic [STATE_W-1:0] ST_SETTLE    = 3'd3;
    localparam logic [STATE_W-1:0] ST_RUN       = 3'd4;
    localparam logic [STATE_W-1:0] ST_FAULT     = 3'd5;

    // Divider payload driven onto the PLL dynamic ports
    typedef struct packed {
        logic [CODE_W-1:0] mdsel;
        logic [CODE_W-1:0] odsel0;
    } div_codes_t;

    // Raw dynamic-port codes (128 minus divider value), 50 MHz reference:
    //   0: M=16 OD=5 -> 160 MHz (boot)   1: M=16 OD=8 -> 100 MHz
    //   2: M=16 OD=4 -> 200 MHz          3: M=20 OD=8 -> 125 MHz
    function automatic div_codes_t prof_codes(input logic [PROF_W-1:0] idx);
        div_codes_t c;
        c = '{mdsel: 7'd112, odsel0: 7'd123};
        case (idx)
            2'd0: c = '{mdsel: 7'd112, odsel0: 7'd123};
            2'd1: c = '{mdsel: 7'd112, odsel0: 7'd120};
            2'd2: c = '{mdsel: 7'd112, odsel0: 7'd124};
            2'd3: c = '{mdsel: 7'd108, odsel0: 7'd120};
        endcase
        return c;
    endfunction

    // Out-of-range profile requests fall back to the boot profile
    function automatic logic [PROF_W-1:0] clamp_prof(input logic [PROF_W-1:0] sel,
                                                     input int unsigned       nprof);
        return (32'(sel) < nprof) ? sel : '0;
    endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_sync.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; the first may go metastable, the second settles
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Run-time PLL CLKOUT0 frequency switcher: gates the clock, resets the PLL,
// applies new divider codes, waits for stable lock, ungates, and supervises
// lock loss while running. Clocked from the free-running board clock.
module pll_reconfig_ctrl
    import pll_cfg_pkg::*;
#(
    parameter int unsigned NPROF        = DEF_NPROF,
    parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int unsigned GATE_CYCLES  = DEF_GATE_CYCLES,
    parameter int unsigned LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int unsigned MAX_RETRY    = DEF_MAX_RETRY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [PROF_W-1:0] sel,
    output logic              ack,
    input  logic              pll_lock,
    output logic              pll_reset,
    output logic [CODE_W-1:0] pll_mdsel,
    output logic [CODE_W-1:0] pll_odsel0,
    output logic              clk_en,
    output logic              ready,
    output logic              fault,
    output logic [PROF_W-1:0] cur_prof,
    output logic [LOSS_W-1:0] loss_cnt
);

    localparam int unsigned PH_MAX = (RESET_CYCLES > GATE_CYCLES) ? RESET_CYCLES : GATE_CYCLES;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
    localparam int unsigned STAB_W = $clog2(LOCK_STABLE + 1);
    localparam int unsigned TMO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned RTY_W  = $clog2(MAX_RETRY + 1);

    localparam logic [PH_W-1:0]   GATE_LAST  = PH_W'(GATE_CYCLES - 1);
    localparam logic [PH_W-1:0]   RESET_LAST = PH_W'(RESET_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_LAST  = STAB_W'(LOCK_STABLE - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [RTY_W-1:0]  RTY_LIMIT  = RTY_W'(MAX_RETRY);

    logic                lock_s;
    logic [STATE_W-1:0]  state,    state_nx;
    logic [PH_W-1:0]     ph_cnt,   ph_nx;
    logic [STAB_W-1:0]   stab_cnt, stab_nx;
    logic [TMO_W-1:0]    tmo_cnt,  tmo_nx;
    logic [RTY_W-1:0]    retry,    retry_nx, retry_inc;
    logic [PROF_W-1:0]   target,   target_nx, req_prof;
    logic                lo_prev,  lo_nx;
    logic                lost;
    logic                ack_nx, prst_nx, en_nx, rdy_nx, fault_nx;
    logic [PROF_W-1:0]   prof_nx;
    logic [LOSS_W-1:0]   loss_nx;
    div_codes_t          codes,    codes_nx;

    assign pll_mdsel  = codes.mdsel;
    assign pll_odsel0 = codes.odsel0;
    assign req_prof   = clamp_prof(sel, NPROF);

    // Lock is asynchronous to the board clock
    sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // State and registered-output flops; reset restarts in PRESET on profile 0
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_PRESET;
            ph_cnt    <= '0;
            stab_cnt  <= '0;
            tmo_cnt   <= '0;
            retry     <= '0;
            target    <= '0;
            lo_prev   <= 1'b0;
            ack       <= 1'b0;
            pll_reset <= 1'b1;
            clk_en    <= 1'b0;
            ready     <= 1'b0;
            fault     <= 1'b0;
            cur_prof  <= '0;
            codes     <= prof_codes('0);
            loss_cnt  <= '0;
        end else begin
            state     <= state_nx;
            ph_cnt    <= ph_nx;
            stab_cnt  <= stab_nx;
            tmo_cnt   <= tmo_nx;
            retry     <= retry_nx;
            target    <= target_nx;
            lo_prev   <= lo_nx;
            ack       <= ack_nx;
            pll_reset <= prst_nx;
            clk_en    <= en_nx;
            ready     <= rdy_nx;
            fault     <= fault_nx;
            cur_prof  <= prof_nx;
            codes     <= codes_nx;
            loss_cnt  <= loss_nx;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nx  = state;
        ph_nx     = ph_cnt;
        stab_nx   = stab_cnt;
        tmo_nx    = tmo_cnt;
        retry_nx  = retry;
        target_nx = target;
        lo_nx     = (state == ST_RUN) && !lock_s;
        ack_nx    = 1'b0;
        prst_nx   = pll_reset;
        en_nx     = clk_en;
        rdy_nx    = ready;
        fault_nx  = fault;
        prof_nx   = cur_prof;
        codes_nx  = codes;
        loss_nx   = loss_cnt;
        lost      = (state == ST_RUN) && lo_prev && !lock_s;
        retry_inc = retry + RTY_W'(1);

        case (state)
            ST_GATE: begin
                if (ph_cnt == GATE_LAST) begin
                    state_nx = ST_PRESET;
                    ph_nx    = '0;
                    prst_nx  = 1'b1;
                end else begin
                    ph_nx = ph_cnt + PH_W'(1);
                end
            end

            ST_PRESET: begin
                // Codes move only here, with the PLL already held in reset
                if (ph_cnt == '0) begin
                    codes_nx = prof_codes(target);
                    prof_nx  = target;
                end
                if (ph_cnt == RESET_LAST) begin
                    state_nx = ST_WAIT_LOCK;
                    ph_nx    = '0;
                    prst_nx  = 1'b0;
                    stab_nx  = '0;
                    tmo_nx   = '0;
                end else begin
                    ph_nx = ph_cnt + PH_W'(1);
                end
            end

            ST_WAIT_LOCK: begin
                if (lock_s && (stab_cnt == STAB_LAST)) begin
                    state_nx = ST_SETTLE;
                    ph_nx    = '0;
                end else begin
                    stab_nx = lock_s ? (stab_cnt + STAB_W'(1)) : '0;
                    if (tmo_cnt == TMO_LAST) begin
                        retry_nx = retry_inc;
                        prst_nx  = 1'b1;
                        ph_nx    = '0;
                        if (retry_inc < RTY_LIMIT) begin
                            state_nx = ST_PRESET;
                        end else begin
                            state_nx = ST_FAULT;
                            fault_nx = 1'b1;
                        end
                    end else begin
                        tmo_nx = tmo_cnt + TMO_W'(1);
                    end
                end
            end

            ST_SETTLE: begin
                if (ph_cnt == GATE_LAST) begin
                    state_nx = ST_RUN;
                    ph_nx    = '0;
                    en_nx    = 1'b1;
                    rdy_nx   = 1'b1;
                    retry_nx = '0;
                end else begin
                    ph_nx = ph_cnt + PH_W'(1);
                end
            end

            ST_RUN: begin
                // A request wins over a simultaneous loss, but the loss is still counted
                if (lost && (loss_cnt != '1)) begin
                    loss_nx = loss_cnt + LOSS_W'(1);
                end
                if (req || lost) begin
                    state_nx = ST_GATE;
                    ph_nx    = '0;
                    en_nx    = 1'b0;
                    rdy_nx   = 1'b0;
                end
                if (req) begin
                    ack_nx    = 1'b1;
                    target_nx = req_prof;
                end
            end

            ST_FAULT: begin
                if (req) begin
                    ack_nx    = 1'b1;
                    fault_nx  = 1'b0;
                    retry_nx  = '0;
                    target_nx = req_prof;
                    state_nx  = ST_GATE;
                    ph_nx     = '0;
                end
            end

            default: begin
                state_nx = ST_PRESET;
                ph_nx    = '0;
                prst_nx  = 1'b1;
                en_nx    = 1'b0;
                rdy_nx   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Bench for pll_reconfig_ctrl: a PLL lock model, a phase-level reference
// model compared every cycle, and directed scenarios with literal timings.
module tb_pll_reconfig_ctrl;

    localparam int NPROF     = 4;
    localparam int RESET_CYC = 16;
    localparam int GATE_CYC  = 4;
    localparam int STABLE    = 32;
    localparam int TIMEOUT   = 400;
    localparam int RETRIES   = 3;
    localparam int LOCK_DLY  = 100;
    localparam int CHAT_END  = 300;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       pll_lock = 1'b0;
    logic       ack, pll_reset, clk_en, ready, fault;
    logic [6:0] pll_mdsel, pll_odsel0;
    logic [1:0] cur_prof;
    logic [7:0] loss_cnt;

    int n_chk = 0;
    int n_pass = 0;
    bit cmp_on = 1'b0;

    int md_tab [4] = '{112, 112, 112, 108};
    int od_tab [4] = '{123, 120, 124, 120};

    always #10 clk = ~clk;

    pll_reconfig_ctrl #(
        .NPROF(NPROF), .RESET_CYCLES(RESET_CYC), .GATE_CYCLES(GATE_CYC),
        .LOCK_STABLE(STABLE), .LOCK_TIMEOUT(TIMEOUT), .MAX_RETRY(RETRIES)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .sel(sel), .ack(ack),
        .pll_lock(pll_lock), .pll_reset(pll_reset), .pll_mdsel(pll_mdsel),
        .pll_odsel0(pll_odsel0), .clk_en(clk_en), .ready(ready), .fault(fault),
        .cur_prof(cur_prof), .loss_cnt(loss_cnt)
    );

    // PLL lock model: 0 normal, 1 never locks, 2 chatters before settling
    int lock_mode = 0;
    int force_low = 0;
    int since = 0;
    always @(negedge clk) begin
        bit lk;
        if (pll_reset) since = 0; else since++;
        case (lock_mode)
            1:       lk = 1'b0;
            2:       lk = !pll_reset && ((since >= CHAT_END) || (since % 21 != 20));
            default: lk = !pll_reset && (since >= LOCK_DLY);
        endcase
        if (force_low > 0) begin
            lk = 1'b0;
            force_low--;
        end
        pll_lock = lk;
    end

    // Reference model: phase plus cycles left in it
    typedef enum {M_GATE, M_PRESET, M_WAIT, M_SETTLE, M_RUN, M_FAULT} mphase_t;
    mphase_t m_ph = M_PRESET;
    int m_left = 0, m_tgt = 0, m_prof = 0, m_retry = 0, m_loss = 0;
    int m_stable = 0, m_waited = 0;
    bit m_low = 0, m_ack = 0, m_rst = 1, m_en = 0, m_rdy = 0, m_flt = 0;
    bit [1:0] m_sync = 2'b00;

    task automatic m_enter_gate();
        m_ph = M_GATE; m_left = GATE_CYC; m_en = 0; m_rdy = 0;
    endtask

    always @(posedge clk) begin
        bit ls, lost;
        if (reset) begin
            m_ph = M_PRESET; m_left = RESET_CYC; m_tgt = 0; m_prof = 0; m_retry = 0;
            m_loss = 0; m_low = 0; m_ack = 0; m_rst = 1; m_en = 0; m_rdy = 0; m_flt = 0;
            m_sync = 2'b00;
        end else begin
            ls = m_sync[1];
            m_sync = {m_sync[0], pll_lock};
            m_ack = 0;
            case (m_ph)
                M_GATE: begin
                    m_left--;
                    if (m_left == 0) begin m_ph = M_PRESET; m_left = RESET_CYC; m_rst = 1; end
                end
                M_PRESET: begin
                    if (m_left == RESET_CYC) m_prof = m_tgt;
                    m_left--;
                    if (m_left == 0) begin m_ph = M_WAIT; m_rst = 0; m_stable = 0; m_waited = 0; end
                end
                M_WAIT: begin
                    m_waited++;
                    m_stable = ls ? m_stable + 1 : 0;
                    if (m_stable == STABLE) begin
                        m_ph = M_SETTLE; m_left = GATE_CYC;
                    end else if (m_waited == TIMEOUT) begin
                        m_retry++;
                        m_rst = 1;
                        if (m_retry < RETRIES) begin m_ph = M_PRESET; m_left = RESET_CYC; end
                        else begin m_ph = M_FAULT; m_flt = 1; end
                    end
                end
                M_SETTLE: begin
                    m_left--;
                    if (m_left == 0) begin m_ph = M_RUN; m_en = 1; m_rdy = 1; m_retry = 0; m_low = 0; end
                end
                M_RUN: begin
                    lost = !ls && m_low;
                    m_low = !ls;
                    if (lost && m_loss < 255) m_loss++;
                    if (req) begin
                        m_ack = 1; m_tgt = (int'(sel) < NPROF) ? int'(sel) : 0; m_enter_gate();
                    end else if (lost) begin
                        m_enter_gate();
                    end
                end
                M_FAULT: begin
                    if (req) begin
                        m_ack = 1; m_flt = 0; m_retry = 0;
                        m_tgt = (int'(sel) < NPROF) ? int'(sel) : 0;
                        m_enter_gate();
                    end
                end
            endcase
        end
    end

    // Per-cycle compare of every output against the model, plus code-change guard
    logic [13:0] prev_codes = '0;
    always @(negedge clk) begin
        logic [28:0] act_v, exp_v;
        if (cmp_on) begin
            act_v = {ack, pll_reset, clk_en, ready, fault, cur_prof, loss_cnt, pll_mdsel, pll_odsel0};
            exp_v = {m_ack, m_rst, m_en, m_rdy, m_flt, 2'(m_prof), 8'(m_loss),
                     7'(md_tab[m_prof]), 7'(od_tab[m_prof])};
            n_chk++;
            if (act_v === exp_v) n_pass++;
            else $display("FAIL model_cycle t=%0t got ack/rst/en/rdy/flt=%b%b%b%b%b prof=%0d loss=%0d md=%0d od=%0d, want %b%b%b%b%b prof=%0d loss=%0d md=%0d od=%0d",
                          $time, ack, pll_reset, clk_en, ready, fault, cur_prof, loss_cnt, pll_mdsel, pll_odsel0,
                          m_ack, m_rst, m_en, m_rdy, m_flt, m_prof, m_loss, md_tab[m_prof], od_tab[m_prof]);
            if ({pll_mdsel, pll_odsel0} !== prev_codes) begin
                n_chk++;
                if (pll_reset === 1'b1) n_pass++;
                else $display("FAIL code_change_guard t=%0t got pll_reset=%b want 1", $time, pll_reset);
            end
        end
        prev_codes = {pll_mdsel, pll_odsel0};
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", name, act, exp);
    endtask

    function automatic logic sigv(input int s);
        case (s)
            0: return ready;
            1: return pll_reset;
            2: return fault;
            default: return ack;
        endcase
    endfunction

    // Wait (from a negedge) until signal s equals v; cyc = negedges waited
    task automatic wait_sig(input int s, input logic v, input int budget, input string name, output int cyc);
        cyc = 0;
        while (sigv(s) !== v && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (sigv(s) !== v) begin
            n_chk++;
            $display("FAIL %s: no change after %0d cycles, got %b want %b", name, budget, sigv(s), v);
        end
    endtask

    // Hold req with sel until acked; cyc = negedges until ack seen
    task automatic do_req(input logic [1:0] s, input int budget, input string name, output int cyc);
        req = 1'b1;
        sel = s;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (ack !== 1'b1 && cyc < budget);
        if (ack !== 1'b1) begin
            n_chk++;
            $display("FAIL %s: no ack after %0d cycles, got %b want 1", name, budget, ack);
        end
        req = 1'b0;
    endtask

    initial begin
        int c;
        repeat (2) @(negedge clk);
        cmp_on = 1'b1;
        // Reset state
        chk("rst_pll_reset", int'(pll_reset), 1);
        chk("rst_clk_en", int'(clk_en), 0);
        chk("rst_ready", int'(ready), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_loss", int'(loss_cnt), 0);
        chk("rst_prof", int'(cur_prof), 0);
        chk("rst_mdsel", int'(pll_mdsel), 112);
        chk("rst_odsel0", int'(pll_odsel0), 123);

        // Boot: lock 100 cycles after reset falls, +2 sync, 32 stable, 4 settle
        reset = 1'b0;
        wait_sig(1, 1'b0, 100, "boot_prst_fall", c);
        wait_sig(0, 1'b1, 1000, "boot_ready", c);
        chk("boot_latency", c, 137);
        chk("boot_prof", int'(cur_prof), 0);
        chk("boot_clk_en", int'(clk_en), 1);

        // Switch to profile 2
        do_req(2'd2, 10, "sw2_ack", c);
        chk("sw2_ack_cycles", c, 1);
        chk("sw2_clk_en_off", int'(clk_en), 0);
        chk("sw2_prst_still_low", int'(pll_reset), 0);
        wait_sig(1, 1'b1, 50, "sw2_prst_rise", c);
        chk("sw2_gate_to_reset", c, 4);
        wait_sig(1, 1'b0, 50, "sw2_prst_fall", c);
        chk("sw2_reset_len", c, 16);
        wait_sig(0, 1'b1, 1000, "sw2_ready", c);
        chk("sw2_lock_to_ready", c, 137);
        chk("sw2_prof", int'(cur_prof), 2);
        chk("sw2_mdsel", int'(pll_mdsel), 112);
        chk("sw2_odsel0", int'(pll_odsel0), 124);

        // Chattering lock: last dropout at 293 cycles after reset release
        do_req(2'd1, 10, "chat_ack", c);
        lock_mode = 2;
        wait_sig(1, 1'b1, 50, "chat_prst_rise", c);
        wait_sig(1, 1'b0, 50, "chat_prst_fall", c);
        wait_sig(0, 1'b1, 2000, "chat_ready", c);
        chk("chat_latency", c, 331);
        lock_mode = 0;

        // Never locks: three timeouts then FAULT; a request recovers
        do_req(2'd3, 10, "nolock_ack", c);
        lock_mode = 1;
        wait_sig(2, 1'b1, 3000, "nolock_fault", c);
        chk("fault_pll_reset", int'(pll_reset), 1);
        chk("fault_clk_en", int'(clk_en), 0);
        chk("fault_ready", int'(ready), 0);
        repeat (20) @(negedge clk);
        chk("fault_sticky", int'(fault), 1);
        lock_mode = 0;
        do_req(2'd1, 10, "fault_ack", c);
        chk("fault_cleared", int'(fault), 0);
        wait_sig(0, 1'b1, 1000, "fault_ready", c);
        chk("fault_recover_prof", int'(cur_prof), 1);

        // Lock loss: one low cycle is tolerated, two counts a loss
        force_low = 1;
        repeat (8) @(negedge clk);
        chk("glitch_loss", int'(loss_cnt), 0);
        chk("glitch_ready", int'(ready), 1);
        force_low = 2;
        wait_sig(0, 1'b0, 20, "loss_ready_drop", c);
        wait_sig(0, 1'b1, 1000, "loss_relock", c);
        chk("loss_one", int'(loss_cnt), 1);
        chk("loss_same_prof", int'(cur_prof), 1);
        for (int i = 0; i < 259; i++) begin
            force_low = 2;
            wait_sig(0, 1'b0, 20, "loss_loop_drop", c);
            wait_sig(0, 1'b1, 1000, "loss_loop_relock", c);
        end
        chk("loss_saturate", int'(loss_cnt), 255);

        // Reset during WAIT_LOCK of profile 3
        do_req(2'd3, 10, "p3_ack", c);
        wait_sig(1, 1'b1, 50, "p3_prst_rise", c);
        wait_sig(1, 1'b0, 50, "p3_prst_fall", c);
        chk("p3_prof", int'(cur_prof), 3);
        chk("p3_mdsel", int'(pll_mdsel), 108);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_pll_reset", int'(pll_reset), 1);
        chk("midrst_prof", int'(cur_prof), 0);
        chk("midrst_mdsel", int'(pll_mdsel), 112);
        chk("midrst_odsel0", int'(pll_odsel0), 123);
        chk("midrst_loss", int'(loss_cnt), 0);
        reset = 1'b0;

        // Request held through WAIT_LOCK is only acked once running
        wait_sig(1, 1'b0, 100, "wreq_prst_fall", c);
        do_req(2'd2, 1000, "wreq_ack", c);
        chk("wreq_ack_delay", c, 138);
        wait_sig(0, 1'b1, 1000, "wreq_ready", c);
        chk("wreq_prof", int'(cur_prof), 2);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
